// File: rtl/router_pkt_src_if.sv
// Packet-source handshake bundle: request, payload load port and router-facing byte stream.
interface router_pkt_src_if;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       reject;

  modport master (
    output start, dest, len, pl_valid, pl_data, busy,
    input  pl_ready, pkt_valid, data_out, tx_active, done, reject
  );

  modport slave (
    input  start, dest, len, pl_valid, pl_data, busy,
    output pl_ready, pkt_valid, data_out, tx_active, done, reject
  );
endinterface

// File: rtl/router_pkt_src.sv
// Store-and-forward packet source: buffers a payload, then emits header, payload and
// XOR parity to a router that can stall each byte with busy.
module router_pkt_src #(
  parameter int GAP_CYCLES = 3
) (
  input logic            clk,
  input logic            resetn,
  router_pkt_src_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;

  logic [5:0]  r_len;
  logic [1:0]  r_dest;
  logic [5:0]  r_wr_cnt;
  logic [5:0]  r_rd_idx;
  logic [3:0]  r_gap;
  logic [7:0]  r_parity;
  logic [7:0]  r_data;
  logic        r_pkt_valid;
  logic        r_tx_active;
  logic        r_done;
  logic        r_reject;
  logic [7:0]  r_buf [64];

  logic [5:0]  w_len;
  logic [1:0]  w_dest;
  logic [5:0]  w_wr_cnt;
  logic [5:0]  w_rd_idx;
  logic [3:0]  w_gap;
  logic [7:0]  w_parity;
  logic [7:0]  w_data;
  logic        w_pkt_valid;
  logic        w_done;
  logic        w_reject;
  logic        w_buf_we;
  logic        w_pl_ready;
  logic        w_accept;
  logic        w_consume;
  logic        w_req_illegal;

  assign w_pl_ready    = (r_state == S_LOAD) && (r_wr_cnt != r_len);
  assign w_accept      = bus.pl_valid && w_pl_ready;
  assign w_consume     = !bus.busy;
  assign w_req_illegal = (bus.dest == 2'd3) || (bus.len == 6'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_len       = r_len;
    w_dest      = r_dest;
    w_wr_cnt    = r_wr_cnt;
    w_rd_idx    = r_rd_idx;
    w_gap       = r_gap;
    w_parity    = r_parity;
    w_data      = r_data;
    w_pkt_valid = r_pkt_valid;
    w_done      = 1'b0;
    w_reject    = 1'b0;
    w_buf_we    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_req_illegal) begin
            w_reject = 1'b1;
          end else begin
            w_len    = bus.len;
            w_dest   = bus.dest;
            w_wr_cnt = 6'd0;
            w_parity = {bus.len, bus.dest};
            w_next   = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (w_accept) begin
          w_buf_we = 1'b1;
          w_parity = r_parity ^ bus.pl_data;
          // Header goes out on the same edge that stores the final payload byte.
          if (r_wr_cnt == r_len - 6'd1) begin
            w_next      = S_HEADER;
            w_data      = {r_len, r_dest};
            w_pkt_valid = 1'b1;
          end else begin
            w_wr_cnt = r_wr_cnt + 6'd1;
          end
        end
      end

      S_HEADER: begin
        if (w_consume) begin
          w_data   = r_buf[0];
          w_rd_idx = 6'd0;
          w_next   = S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        if (w_consume) begin
          if (r_rd_idx == r_len - 6'd1) begin
            w_data      = r_parity;
            w_pkt_valid = 1'b0;
            w_next      = S_PARITY;
          end else begin
            w_rd_idx = r_rd_idx + 6'd1;
            w_data   = r_buf[r_rd_idx + 6'd1];
          end
        end
      end

      S_PARITY: begin
        if (w_consume) begin
          w_done = 1'b1;
          w_data = 8'h00;
          w_gap  = GAP_LAST;
          w_next = S_GAP;
        end
      end

      S_GAP: begin
        if (r_gap == 4'd0) begin
          w_next = S_IDLE;
        end else begin
          w_gap = r_gap - 4'd1;
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_len       <= 6'd0;
      r_dest      <= 2'd0;
      r_wr_cnt    <= 6'd0;
      r_rd_idx    <= 6'd0;
      r_gap       <= 4'd0;
      r_parity    <= 8'h00;
      r_data      <= 8'h00;
      r_pkt_valid <= 1'b0;
      r_tx_active <= 1'b0;
      r_done      <= 1'b0;
      r_reject    <= 1'b0;
    end else begin
      r_len       <= w_len;
      r_dest      <= w_dest;
      r_wr_cnt    <= w_wr_cnt;
      r_rd_idx    <= w_rd_idx;
      r_gap       <= w_gap;
      r_parity    <= w_parity;
      r_data      <= w_data;
      r_pkt_valid <= w_pkt_valid;
      r_tx_active <= (w_next != S_IDLE);
      r_done      <= w_done;
      r_reject    <= w_reject;
    end
  end

  // Payload store has no reset; stale contents are never read past len-1.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_wr_cnt] <= bus.pl_data;
    end
  end

  assign bus.pl_ready  = w_pl_ready;
  assign bus.pkt_valid = r_pkt_valid;
  assign bus.data_out  = r_data;
  assign bus.tx_active = r_tx_active;
  assign bus.done      = r_done;
  assign bus.reject    = r_reject;

endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: directed and randomized packets checked against a queue-based packet model.
module tb_router_pkt_src;
  localparam int GAP = 3;

  logic clk = 1'b0;
  logic resetn;
  router_pkt_src_if bus();

  router_pkt_src #(.GAP_CYCLES(GAP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] pl_q[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk1({tag, "_pkt_valid"}, bus.pkt_valid, 1'b0);
    chk8({tag, "_data_out"},  bus.data_out,  8'h00);
    chk1({tag, "_pl_ready"},  bus.pl_ready,  1'b0);
    chk1({tag, "_tx_active"}, bus.tx_active, 1'b0);
    chk1({tag, "_done"},      bus.done,      1'b0);
    chk1({tag, "_reject"},    bus.reject,    1'b0);
  endtask

  task automatic fill_payload(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask

  // Sends one packet using pl_q as payload; abort_at >= 0 resets the DUT when that
  // many output bytes have been consumed.
  task automatic run_packet(input logic [1:0] d, input logic [5:0] l, input bit rand_valid,
                            input int stall_hdr, input bit rand_busy, input int abort_at);
    logic [7:0] exp_b[$];
    bit         exp_v[$];
    logic [7:0] par;
    int idx, guard, cyc, got, hold, extra, busy_cycles, stall_left;
    bit started, accept;

    par = {l, d};
    exp_b.push_back(par);
    exp_v.push_back(1'b1);
    for (int i = 0; i < int'(l); i++) begin
      exp_b.push_back(pl_q[i]);
      exp_v.push_back(1'b1);
      par ^= pl_q[i];
    end
    exp_b.push_back(par);
    exp_v.push_back(1'b0);

    bus.start = 1'b1;
    bus.dest  = d;
    bus.len   = l;
    step();
    bus.start = 1'b0;
    chk1("load_tx_active", bus.tx_active, 1'b1);

    idx = 0;
    guard = 0;
    while (idx < int'(l) && guard < 2000) begin
      bus.pl_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pl_data  = pl_q[idx];
      accept = bus.pl_valid && bus.pl_ready;
      step();
      guard++;
      if (accept) idx++;
    end
    chki("load_accepted", idx, int'(l));
    chk1("pl_ready_after_last", bus.pl_ready, 1'b0);
    bus.pl_valid = 1'b1;
    bus.pl_data  = 8'hA5;

    got = 0; guard = 0; cyc = 0; hold = 0; extra = 0; busy_cycles = 0;
    started = 1'b0;
    stall_left = stall_hdr;
    while (got < int'(l) + 2 && guard < 4000) begin
      guard++;
      if (bus.pkt_valid) started = 1'b1;
      if (bus.pl_ready) extra++;
      if (started && abort_at == got) begin
        resetn = 1'b0;
        #1;
        check_quiet("midreset");
        bus.busy = 1'b0;
        bus.pl_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        chk1("post_midreset_idle", bus.tx_active, 1'b0);
        return;
      end
      bus.busy = 1'b0;
      if (started) begin
        if (stall_left > 0 && got == 0) begin
          bus.busy = 1'b1;
          stall_left--;
        end else if (rand_busy) begin
          bus.busy = ($urandom_range(0, 3) == 0);
        end
        cyc++;
        if (got == 0) hold++;
        if (bus.busy) begin
          busy_cycles++;
        end else begin
          chk8($sformatf("byte%0d_data", got), bus.data_out, exp_b[got]);
          chk1($sformatf("byte%0d_valid", got), bus.pkt_valid, exp_v[got]);
          got++;
        end
      end
      step();
    end
    bus.busy = 1'b0;
    bus.pl_valid = 1'b0;
    chki("out_bytes", got, int'(l) + 2);
    chki("out_cycles", cyc, int'(l) + 2 + busy_cycles);
    chki("no_extra_accept", extra, 0);
    if (stall_hdr > 0) chki("hdr_hold", hold, stall_hdr + 1);

    chk1("done_pulse", bus.done, 1'b1);
    chk8("gap_data", bus.data_out, 8'h00);
    chk1("gap_pkt_valid", bus.pkt_valid, 1'b0);

    bus.start = 1'b1;
    bus.dest  = 2'd0;
    bus.len   = 6'd5;
    for (int k = 1; k < GAP; k++) begin
      step();
      chk1("gap_tx_active", bus.tx_active, 1'b1);
      chk1("done_single", bus.done, 1'b0);
    end
    step();
    chk1("gap_end_idle", bus.tx_active, 1'b0);
    bus.start = 1'b0;
    step();
    chk1("gap_start_ignored", bus.tx_active, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dest = 2'd0;
    bus.len = 6'd0;
    bus.pl_valid = 1'b0;
    bus.pl_data = 8'h00;
    bus.busy = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1 check_quiet("reset");
    repeat (3) step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("idle_after_reset", bus.tx_active, 1'b0);
    end

    pl_q = '{8'h11, 8'h22, 8'h33};
    run_packet(2'd1, 6'd3, 1'b0, 0, 1'b0, -1);

    pl_q = '{8'h11, 8'h22, 8'h33};
    run_packet(2'd1, 6'd3, 1'b0, 2, 1'b0, -1);

    bus.start = 1'b1; bus.dest = 2'd3; bus.len = 6'd4;
    step();
    bus.start = 1'b0;
    chk1("ill_dest_reject", bus.reject, 1'b1);
    chk1("ill_dest_pkt_valid", bus.pkt_valid, 1'b0);
    chk1("ill_dest_tx_active", bus.tx_active, 1'b0);
    step();
    chk1("ill_dest_reject_once", bus.reject, 1'b0);
    chk1("ill_dest_stay_idle", bus.tx_active, 1'b0);

    bus.start = 1'b1; bus.dest = 2'd1; bus.len = 6'd0;
    step();
    bus.start = 1'b0;
    chk1("ill_len_reject", bus.reject, 1'b1);
    chk1("ill_len_pkt_valid", bus.pkt_valid, 1'b0);
    chk1("ill_len_tx_active", bus.tx_active, 1'b0);
    step();
    chk1("ill_len_reject_once", bus.reject, 1'b0);
    chk1("ill_len_stay_idle", bus.tx_active, 1'b0);

    fill_payload(63);
    run_packet(2'd2, 6'd63, 1'b1, 0, 1'b0, -1);

    pl_q = '{8'h5C};
    run_packet(2'd0, 6'd1, 1'b0, 0, 1'b0, -1);

    for (int n = 0; n < 4; n++) begin
      logic [1:0] rd;
      logic [5:0] rl;
      rd = 2'($urandom_range(0, 2));
      rl = 6'($urandom_range(1, 20));
      fill_payload(int'(rl));
      run_packet(rd, rl, 1'b1, 0, 1'b1, -1);
    end

    fill_payload(4);
    run_packet(2'd1, 6'd4, 1'b0, 0, 1'b0, 2);
    fill_payload(5);
    run_packet(2'd0, 6'd5, 1'b1, 0, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
